axis_packetizer: RTL

- Local-port injection stage that sits directly upstream of a router input channel. It converts a raw AXI-Stream frame from a processing node into one or more NoC packets.
- Each packet is one header flit followed by up to MAX_PAYLOAD payload flits.
- The header carries the target X/Y coordinates that the router's routing stage consumes, plus the payload flit count.
- The block is store-and-forward: it buffers up to one packet of payload before emitting the header.

---
 rtl/axis_packetizer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/axis_packetizer.sv
// Store-and-forward AXI-Stream to NoC packetizer: one header flit (x, y, count) then up to MAX_PAYLOAD flits.
// Optional macro PACKETIZER_SRC_STAMP_EN adds this router's X/Y as a source field in the header.
module axis_packetizer #(
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_ROUTERS_X = 4,
    parameter int MAX_ROUTERS_Y = 4,
    parameter int ROUTER_X      = 0,
    parameter int ROUTER_Y      = 0,
    parameter int MAX_PAYLOAD   = 4,
    localparam int XW = $clog2(MAX_ROUTERS_X),
    localparam int YW = $clog2(MAX_ROUTERS_Y),
    localparam int CW = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] s_tdata_i,
    input  logic [XW+YW-1:0]      s_tdest_i,
    input  logic                  s_tvalid_i,
    input  logic                  s_tlast_i,
    output logic                  s_tready_o,
    output logic [DATA_WIDTH-1:0] m_tdata_o,
    output logic                  m_tvalid_o,
    output logic                  m_tlast_o,
    input  logic                  m_tready_i,
    output logic                  bad_dest_o
);

`ifdef PACKETIZER_SRC_STAMP_EN
    localparam int HDR_W = 2 * (XW + YW) + CW;
`else
    localparam int HDR_W = XW + YW + CW;
`endif

    generate
        if (DATA_WIDTH < HDR_W) begin : g_width_chk
            $error("axis_packetizer: DATA_WIDTH too small for header fields");
        end
    endgenerate

    localparam logic [XW:0]   MAXX    = MAX_ROUTERS_X[XW:0];
    localparam logic [YW:0]   MAXY    = MAX_ROUTERS_Y[YW:0];
    localparam logic [CW-1:0] MAXP_M1 = CW'(MAX_PAYLOAD - 1);

    typedef enum logic [2:0] {IDLE, FILL, HEADER, PAYLOAD, DROP} state_t;
    state_t state, state_nxt;

    logic [XW-1:0]         tgt_x;
    logic [YW-1:0]         tgt_y;
    logic [CW-1:0]         count, idx;
    logic                  frame_done, bad_dest_q;
    logic [DATA_WIDTH-1:0] pld_mem [0:(1<<CW)-1];
    logic [DATA_WIDTH-1:0] hdr;
    logic [XW-1:0]         in_dx;
    logic [YW-1:0]         in_dy;
    logic                  dest_bad, pld_last;

    assign in_dx    = s_tdest_i[XW-1:0];
    assign in_dy    = s_tdest_i[XW+YW-1:XW];
    assign dest_bad = ({1'b0, in_dx} >= MAXX) | ({1'b0, in_dy} >= MAXY);
    assign pld_last = (idx == count - 1'b1);

    always_comb begin
        hdr = '0;
        hdr[XW-1:0]           = tgt_x;
        hdr[XW+YW-1:XW]       = tgt_y;
        hdr[XW+YW+CW-1:XW+YW] = count;
`ifdef PACKETIZER_SRC_STAMP_EN
        hdr[XW+YW+CW +: XW]   = XW'(ROUTER_X);
        hdr[2*XW+YW+CW +: YW] = YW'(ROUTER_Y);
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        s_tready_o = 1'b0;
        m_tvalid_o = 1'b0;
        m_tdata_o  = '0;
        m_tlast_o  = 1'b0;
        case (state)
            IDLE: begin
                s_tready_o = 1'b1;
                if (s_tvalid_i) begin
                    if (dest_bad)
                        state_nxt = s_tlast_i ? IDLE : DROP;
                    else if (s_tlast_i || MAX_PAYLOAD == 1)
                        state_nxt = HEADER;
                    else
                        state_nxt = FILL;
                end
            end
            FILL: begin
                s_tready_o = 1'b1;
                if (s_tvalid_i && (s_tlast_i || count == MAXP_M1))
                    state_nxt = HEADER;
            end
            HEADER: begin
                m_tvalid_o = 1'b1;
                m_tdata_o  = hdr;
                if (m_tready_i) state_nxt = PAYLOAD;
            end
            PAYLOAD: begin
                m_tvalid_o = 1'b1;
                m_tdata_o  = pld_mem[idx];
                m_tlast_o  = pld_last;
                if (m_tready_i && pld_last)
                    state_nxt = frame_done ? IDLE : FILL;
            end
            DROP: begin
                s_tready_o = 1'b1;
                if (s_tvalid_i && s_tlast_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tgt_x      <= '0;
            tgt_y      <= '0;
            count      <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
            bad_dest_q <= 1'b0;
        end else begin
            bad_dest_q <= 1'b0;
            case (state)
                IDLE: if (s_tvalid_i) begin
                    tgt_x      <= in_dx;
                    tgt_y      <= in_dy;
                    bad_dest_q <= dest_bad;
                    count      <= CW'(1);
                    frame_done <= s_tlast_i;
                end
                FILL: if (s_tvalid_i) begin
                    count      <= count + 1'b1;
                    frame_done <= s_tlast_i;
                end
                HEADER: if (m_tready_i) idx <= '0;
                // A split frame restarts filling with the same latched target.
                PAYLOAD: if (m_tready_i) begin
                    idx <= idx + 1'b1;
                    if (pld_last && !frame_done) count <= '0;
                end
                default: ;
            endcase
        end
    end

    // Payload storage needs no reset; count/idx gate every read.
    always_ff @(posedge clk_i) begin
        if (s_tvalid_i && state == IDLE)
            pld_mem[0] <= s_tdata_i;
        else if (s_tvalid_i && state == FILL)
            pld_mem[count] <= s_tdata_i;
    end

    assign bad_dest_o = bad_dest_q;

endmodule
